// File: rtl/dcl_tag_scanner.sv
`default_nettype none
// dcl_tag_scanner: forwards the SD byte-stream payload found between "DCL_START" and "DCL_END" through a small FIFO.
// Optional macro CASE_FOLD_EN: case-insensitive tag matching and upper-cased payload bytes.
module dcl_tag_scanner #(
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             scan_start,
    input  logic [7:0]       sd_dout,
    input  logic             sd_valid,
    output logic [7:0]       pay_data,
    output logic             pay_valid,
    input  logic             pay_ready,
    output logic             searching,
    output logic             in_payload,
    output logic             scan_done,
    output logic [LEN_W-1:0] pay_len,
    output logic             overflow
);
    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [71:0] C_TAG_START = "DCL_START";
    localparam logic [55:0] C_TAG_END   = "DCL_END";

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEARCH  = 2'd1,
        S_PAYLOAD = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           state_q;
    logic [63:0]      srch_win_q;   // previous 8 bytes; the incoming byte completes the 9-byte window
    logic [55:0]      pay_win_q;
    logic [2:0]       fill_q;
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [LEN_W-1:0] pay_len_q;
    logic             overflow_q;
    logic [7:0]       mem_q [FIFO_DEPTH];

    function automatic logic [7:0] fold_byte(input logic [7:0] b);
`ifdef CASE_FOLD_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
        return b;
    endfunction

    logic [71:0] srch_win_d;
    logic [71:0] srch_fold;
    logic [55:0] pay_win_d;
    logic [55:0] pay_fold;

    always_comb begin
        srch_win_d = {srch_win_q, sd_dout};
        pay_win_d  = {pay_win_q[47:0], sd_dout};
        srch_fold  = '0;
        pay_fold   = '0;
        for (int i = 0; i < 9; i++) srch_fold[i*8 +: 8] = fold_byte(srch_win_d[i*8 +: 8]);
        for (int i = 0; i < 7; i++) pay_fold[i*8 +: 8]  = fold_byte(pay_win_d[i*8 +: 8]);
    end

    logic       accept;
    logic       start_hit;
    logic       pay_shift;
    logic       end_hit;
    logic       wr_req;
    logic [7:0] wr_data;
    logic       fifo_full;
    logic       rd_en;
    logic       wr_commit;

    assign accept    = sd_valid && !scan_start;
    assign start_hit = (state_q == S_SEARCH) && accept && (srch_fold == C_TAG_START);
    assign pay_shift = (state_q == S_PAYLOAD) && accept;
    assign end_hit   = pay_shift && (pay_fold == C_TAG_END);
    // Only a full hold-back window evicts a byte, so tag bytes never reach the FIFO.
    assign wr_req    = pay_shift && (fill_q == 3'd7);
    assign wr_data   = fold_byte(pay_win_q[55:48]);
    assign fifo_full = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
    assign pay_valid = (wr_ptr_q != rd_ptr_q);
    assign rd_en     = pay_valid && pay_ready;
    assign wr_commit = wr_req && (!fifo_full || rd_en);
    assign pay_data  = pay_valid ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;

    assign searching  = (state_q == S_SEARCH);
    assign in_payload = (state_q == S_PAYLOAD);
    assign scan_done  = (state_q == S_DONE);
    assign pay_len    = pay_len_q;
    assign overflow   = overflow_q;

    always_ff @(posedge clk) begin
        if (wr_commit) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            srch_win_q <= '0;
            pay_win_q  <= '0;
            fill_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pay_len_q  <= '0;
            overflow_q <= 1'b0;
        end else if (scan_start) begin
            state_q    <= S_SEARCH;
            srch_win_q <= '0;
            pay_win_q  <= '0;
            fill_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pay_len_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            if (wr_commit) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
                if (pay_len_q != '1) pay_len_q <= pay_len_q + LEN_W'(1);
            end
            if (wr_req && !wr_commit) overflow_q <= 1'b1;

            case (state_q)
                S_SEARCH: begin
                    if (sd_valid) begin
                        srch_win_q <= srch_win_d[63:0];
                        if (start_hit) begin
                            state_q   <= S_PAYLOAD;
                            pay_win_q <= '0;
                            fill_q    <= '0;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (sd_valid) begin
                        if (end_hit) begin
                            state_q   <= S_DONE;
                            pay_win_q <= '0;
                            fill_q    <= '0;
                        end else begin
                            pay_win_q <= pay_win_d;
                            if (fill_q != 3'd7) fill_q <= fill_q + 3'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dcl_tag_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// Directed self-checking bench for dcl_tag_scanner: tag extraction, split tags, FIFO overflow/pass-through, async reset.
module tb_dcl_tag_scanner;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        scan_start = 1'b0;
    logic [7:0]  sd_dout = 8'h00;
    logic        sd_valid = 1'b0;
    logic        pay_ready = 1'b0;
    logic [7:0]  pay_data;
    logic        pay_valid;
    logic        searching;
    logic        in_payload;
    logic        scan_done;
    logic [15:0] pay_len;
    logic        overflow;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  rx_q[$];

    always #5 clk = ~clk;

    dcl_tag_scanner #(.FIFO_DEPTH(16), .LEN_W(16)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .scan_start (scan_start),
        .sd_dout    (sd_dout),
        .sd_valid   (sd_valid),
        .pay_data   (pay_data),
        .pay_valid  (pay_valid),
        .pay_ready  (pay_ready),
        .searching  (searching),
        .in_payload (in_payload),
        .scan_done  (scan_done),
        .pay_len    (pay_len),
        .overflow   (overflow)
    );

    // Consumer side: a transfer seen mid-cycle completes on the following rising edge.
    always @(negedge clk) begin
        if (reset_n && pay_valid && pay_ready) rx_q.push_back(pay_data);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #2;
        sd_dout  = b;
        sd_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
            sd_valid = 1'b0;
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        idle(1);
    endtask

    task automatic start_scan();
        @(posedge clk); #2;
        sd_valid   = 1'b0;
        scan_start = 1'b1;
        @(posedge clk); #2;
        scan_start = 1'b0;
        rx_q.delete();
    endtask

    task automatic chk_rx(input string tag, input string exp_s);
        chk({tag, "_count"}, rx_q.size(), exp_s.len());
        for (int i = 0; i < exp_s.len() && i < rx_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_s[i]);
    endtask

    initial begin
        // Reset state
        idle(2);
        chk("rst_searching", searching, 0);
        chk("rst_in_payload", in_payload, 0);
        chk("rst_scan_done", scan_done, 0);
        chk("rst_pay_valid", pay_valid, 0);
        chk("rst_pay_data", pay_data, 0);
        chk("rst_pay_len", pay_len, 0);
        chk("rst_overflow", overflow, 0);
        reset_n = 1'b1;
        send_str("DCL_STARTab");
        chk("idle_ignores_bytes", searching, 0);

        // Basic extraction
        pay_ready = 1'b1;
        start_scan();
        chk("b_searching", searching, 1);
        send_str("xxDCL_START");
        chk("b_in_payload", in_payload, 1);
        send_str("RGBpyDCL_END");
        idle(4);
        chk("b_scan_done", scan_done, 1);
        chk("b_pay_len", pay_len, 5);
        chk("b_overflow", overflow, 0);
        chk_rx("b_rx", "RGBpy");
        send_str("DCL_STARTzzzzzzzzzz");
        idle(4);
        chk("b_done_ignores", pay_len, 5);
        chk("b_done_stays", scan_done, 1);

        // Overlapping prefix
        start_scan();
        send_str("DCL_DCL_START");
        chk("ovl_in_payload", in_payload, 1);

        // Start tag split across a sector boundary
        start_scan();
        for (int i = 0; i < 506; i++) send_byte(8'h2E);
        send_str("DCL_ST");
        idle(100);
        chk("split_still_search", searching, 1);
        send_str("ART");
        chk("split_in_payload", in_payload, 1);

        // Overflow: 20 payload bytes into a 16-entry FIFO
        pay_ready = 1'b0;
        start_scan();
        send_str("DCL_START");
        for (int i = 1; i <= 20; i++) send_byte(8'(i));
        send_str("DCL_END");
        chk("of_overflow", overflow, 1);
        chk("of_pay_len", pay_len, 16);
        chk("of_scan_done", scan_done, 1);
        chk("of_pay_valid", pay_valid, 1);
        chk("of_head", pay_data, 8'h01);
        pay_ready = 1'b1;
        idle(24);
        chk("of_rx_count", rx_q.size(), 16);
        for (int i = 0; i < 16 && i < rx_q.size(); i++)
            chk($sformatf("of_rx%0d", i), rx_q[i], 8'(i + 1));
        chk("of_drained", pay_valid, 0);

        // Full FIFO: simultaneous read and write is a pass-through
        pay_ready = 1'b0;
        start_scan();
        send_str("DCL_START");
        for (int i = 1; i <= 23; i++) send_byte(8'(i));
        idle(1);
        chk("pt_len_full", pay_len, 16);
        chk("pt_ovf_before", overflow, 0);
        @(posedge clk); #2;
        sd_dout   = 8'd24;
        sd_valid  = 1'b1;
        pay_ready = 1'b1;
        @(posedge clk); #2;
        sd_valid  = 1'b0;
        pay_ready = 1'b0;
        chk("pt_ovf_after", overflow, 0);
        chk("pt_len_after", pay_len, 17);
        chk("pt_one_read", rx_q.size(), 1);
        pay_ready = 1'b1;
        idle(24);
        chk("pt_rx_count", rx_q.size(), 17);
        for (int i = 0; i < 17 && i < rx_q.size(); i++)
            chk($sformatf("pt_rx%0d", i), rx_q[i], 8'(i + 1));

        // Case folding
        start_scan();
        send_str("dcl_startrgDcl_end");
        idle(4);
`ifdef CASE_FOLD_EN
        chk("cf_scan_done", scan_done, 1);
        chk_rx("cf_rx", "RG");
`else
        chk("cf_searching", searching, 1);
        chk("cf_no_output", rx_q.size(), 0);
        chk("cf_pay_len", pay_len, 0);
`endif

        // Asynchronous reset mid-payload with 5 bytes queued
        pay_ready = 1'b0;
        start_scan();
        send_str("DCL_START");
        send_str("123456789012");
        chk("ar_pre_len", pay_len, 5);
        chk("ar_pre_valid", pay_valid, 1);
        @(negedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("ar_in_payload", in_payload, 0);
        chk("ar_searching", searching, 0);
        chk("ar_pay_valid", pay_valid, 0);
        chk("ar_pay_len", pay_len, 0);
        chk("ar_overflow", overflow, 0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        idle(2);
        chk("ar_idle_after", searching, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
